// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared read-mode constants and sizing helpers for sync_fifo_mm
package sync_fifo_pkg;

  localparam int FWFT_MODE = 1;
  localparam int STD_MODE  = 0;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so DEPTH need not be a power of two
  function automatic int next_wrap(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - modulo-DEPTH pointer with synchronous clear
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (i_clr) begin
      ptr <= '0;
    end else if (i_inc) begin
      ptr <= PW'(next_wrap(int'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/sync_fifo_mm.sv
// rtl/sync_fifo_mm.sv - single-clock FIFO, any depth, FWFT or registered read, programmable flags
module sync_fifo_mm
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5,
  parameter int FWFT   = 1,
  parameter int CW     = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  input  logic [CW-1:0]     i_afull_th,
  input  logic [CW-1:0]     i_aempty_th,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CW-1:0]     o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrptr;
  logic [PW-1:0]     rdptr;
  logic [CW-1:0]     count;
  logic              wr_acc;
  logic              rd_acc;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);

  // Flush wins over same-cycle traffic
  assign wr_acc = i_wren & ~o_full  & ~i_flush;
  assign rd_acc = i_rden & ~o_empty & ~i_flush;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wrptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_flush),
    .i_inc (wr_acc),
    .ptr   (wrptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rdptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_flush),
    .i_inc (rd_acc),
    .ptr   (rdptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wrptr] <= i_wrdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (i_flush) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren && o_full)  o_overflow  <= 1'b1;
      if (i_rden && o_empty) o_underflow <= 1'b1;
    end
  end

  assign o_count     = count;
  assign o_alm_full  = (i_afull_th == '0) || (count >= i_afull_th);
  assign o_alm_empty = (i_aempty_th >= CW'(DEPTH)) || (count <= i_aempty_th);

  generate
    if (FWFT == FWFT_MODE) begin : g_fwft
      assign o_rddata  = mem[rdptr];
      assign o_rdvalid = ~o_empty;
    end else begin : g_std
      logic [DATA_W-1:0] rddata_q;
      logic              rdvalid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rddata_q  <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          rdvalid_q <= rd_acc;
          if (rd_acc) rddata_q <= mem[rdptr];
        end
      end

      assign o_rddata  = rddata_q;
      assign o_rdvalid = rdvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_mm.sv
// tb/tb_sync_fifo_mm.sv - directed bench for sync_fifo_mm in FWFT and registered-read modes
module tb_sync_fifo_mm;

  localparam int DW = 8;
  localparam int DP = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] wrdata = '0;
  logic          rden = 1'b0;
  logic [CW-1:0] afull_th = 3'd4;
  logic [CW-1:0] aempty_th = 3'd1;

  logic [DW-1:0] f_rddata, s_rddata;
  logic          f_rdvalid, s_rdvalid;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [CW-1:0] f_count, s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_mm #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata),
    .i_rden(rden), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid),
    .i_afull_th(afull_th), .i_aempty_th(aempty_th), .o_full(f_full),
    .o_empty(f_empty), .o_alm_full(f_afull), .o_alm_empty(f_aempty),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  sync_fifo_mm #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata),
    .i_rden(rden), .o_rddata(s_rddata), .o_rdvalid(s_rdvalid),
    .i_afull_th(afull_th), .i_aempty_th(aempty_th), .o_full(s_full),
    .o_empty(s_empty), .o_alm_full(s_afull), .o_alm_empty(s_aempty),
    .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (f_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", f_count); end
    tests++;
    if (f_empty !== 1'b1 || f_full !== 1'b0) begin
      fails++; $display("FAIL reset_flags: empty=%0b full=%0b expected empty=1 full=0", f_empty, f_full);
    end
    tests++;
    if (f_aempty !== 1'b1 || f_afull !== 1'b0) begin
      fails++; $display("FAIL reset_alm: aempty=%0b afull=%0b expected 1/0", f_aempty, f_afull);
    end
    tests++;
    if (f_ovf !== 1'b0 || f_udf !== 1'b0 || f_rdvalid !== 1'b0) begin
      fails++; $display("FAIL reset_err: ovf=%0b udf=%0b rdvalid=%0b expected 0/0/0", f_ovf, f_udf, f_rdvalid);
    end
    tests++;
    if (s_rddata !== 8'h00 || s_rdvalid !== 1'b0) begin
      fails++; $display("FAIL reset_std: rddata=%0h rdvalid=%0b expected 0/0", s_rddata, s_rdvalid);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp;
    for (int i = 0; i < DP; i++) begin
      wren = 1'b1;
      wrdata = 8'(8'h11 * (i + 1));
      step();
      tests++;
      if (f_count !== 3'(i + 1) || f_afull !== (i + 1 >= 4) || f_full !== (i == DP - 1)) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d afull=%0b full=%0b expected %0d/%0b/%0b",
                 i, f_count, f_afull, f_full, i + 1, (i + 1 >= 4), (i == DP - 1));
      end
    end
    wren = 1'b0;
    for (int i = 0; i < DP; i++) begin
      exp = 8'(8'h11 * (i + 1));
      tests++;
      if (f_rddata !== exp || f_rdvalid !== 1'b1) begin
        fails++; $display("FAIL drain_data_%0d: got %0h valid=%0b expected %0h valid=1", i, f_rddata, f_rdvalid, exp);
      end
      rden = 1'b1;
      step();
      tests++;
      if (f_count !== 3'(DP - 1 - i) || f_aempty !== (DP - 1 - i <= 1)) begin
        fails++;
        $display("FAIL drain_cnt_%0d: count=%0d aempty=%0b expected %0d/%0b",
                 i, f_count, f_aempty, DP - 1 - i, (DP - 1 - i <= 1));
      end
    end
    rden = 1'b0;
    tests++;
    if (f_empty !== 1'b1 || f_rdvalid !== 1'b0) begin
      fails++; $display("FAIL drain_empty: empty=%0b rdvalid=%0b expected 1/0", f_empty, f_rdvalid);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp;
    int            rd_bad;
    rd_bad = 0;
    for (int i = 0; i < 3; i++) begin
      wren = 1'b1; wrdata = 8'(8'h60 + i); step();
    end
    wren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = 8'(8'h60 + i);
      if (f_rddata !== exp) rd_bad++;
      rden = 1'b1; step();
    end
    rden = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wren = 1'b1; wrdata = 8'(8'h80 + i); step();
    end
    wren = 1'b0;
    tests++;
    if (f_full !== 1'b1) begin fails++; $display("FAIL wrap_full: got %0b expected 1", f_full); end
    for (int i = 0; i < 5; i++) begin
      exp = 8'(8'h80 + i);
      tests++;
      if (f_rddata !== exp) begin fails++; $display("FAIL wrap_data_%0d: got %0h expected %0h", i, f_rddata, exp); end
      rden = 1'b1; step();
    end
    rden = 1'b0;
    tests++;
    if (rd_bad != 0) begin fails++; $display("FAIL wrap_first3: %0d bad words expected 0", rd_bad); end
    tests++;
    if (f_count !== 3'd0 || f_ovf !== 1'b0 || f_udf !== 1'b0) begin
      fails++; $display("FAIL wrap_end: count=%0d ovf=%0b udf=%0b expected 0/0/0", f_count, f_ovf, f_udf);
    end
  endtask

  task automatic test_std_latency();
    flush = 1'b1; step(); flush = 1'b0;
    wren = 1'b1; wrdata = 8'hA5; step(); wren = 1'b0;
    tests++;
    if (s_rdvalid !== 1'b0) begin fails++; $display("FAIL std_pre: rdvalid=%0b expected 0", s_rdvalid); end
    rden = 1'b1; step(); rden = 1'b0;
    tests++;
    if (s_rddata !== 8'hA5 || s_rdvalid !== 1'b1) begin
      fails++; $display("FAIL std_read: rddata=%0h rdvalid=%0b expected a5/1", s_rddata, s_rdvalid);
    end
    step();
    tests++;
    if (s_rdvalid !== 1'b0 || s_rddata !== 8'hA5) begin
      fails++; $display("FAIL std_post: rddata=%0h rdvalid=%0b expected a5/0", s_rddata, s_rdvalid);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < DP; i++) begin
      wren = 1'b1; wrdata = 8'(8'hB0 + i); step();
    end
    rden = 1'b1; wrdata = 8'hFF; step();
    wren = 1'b0; rden = 1'b0;
    tests++;
    if (f_count !== 3'd4 || f_ovf !== 1'b1 || f_udf !== 1'b0) begin
      fails++; $display("FAIL full_rw: count=%0d ovf=%0b udf=%0b expected 4/1/0", f_count, f_ovf, f_udf);
    end
    step();
    tests++;
    if (f_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b expected 1", f_ovf); end
    for (int i = 1; i < DP; i++) begin
      tests++;
      if (f_rddata !== 8'(8'hB0 + i)) begin
        fails++; $display("FAIL full_rw_data_%0d: got %0h expected %0h", i, f_rddata, 8'(8'hB0 + i));
      end
      rden = 1'b1; step();
    end
    wren = 1'b1; wrdata = 8'hC3; step();
    wren = 1'b0; rden = 1'b0;
    tests++;
    if (f_count !== 3'd1 || f_udf !== 1'b1 || f_rddata !== 8'hC3) begin
      fails++; $display("FAIL empty_rw: count=%0d udf=%0b data=%0h expected 1/1/c3", f_count, f_udf, f_rddata);
    end
  endtask

  task automatic test_flush();
    wren = 1'b1; wrdata = 8'hD1; step(); wrdata = 8'hD2; step();
    tests++;
    if (f_count !== 3'd3) begin fails++; $display("FAIL flush_pre: count=%0d expected 3", f_count); end
    flush = 1'b1; wrdata = 8'hEE; step();
    flush = 1'b0; wren = 1'b0;
    tests++;
    if (f_count !== 3'd0 || f_empty !== 1'b1 || f_ovf !== 1'b0 || f_udf !== 1'b0 || s_rdvalid !== 1'b0) begin
      fails++; $display("FAIL flush: count=%0d empty=%0b ovf=%0b udf=%0b rdvalid=%0b expected 0/1/0/0/0",
                        f_count, f_empty, f_ovf, f_udf, s_rdvalid);
    end
    wren = 1'b1; wrdata = 8'h5A; step(); wren = 1'b0;
    tests++;
    if (f_count !== 3'd1 || f_rddata !== 8'h5A) begin
      fails++; $display("FAIL flush_after: count=%0d data=%0h expected 1/5a", f_count, f_rddata);
    end
  endtask

  task automatic test_thresholds();
    afull_th = 3'd0; #1;
    tests++;
    if (f_afull !== 1'b1) begin fails++; $display("FAIL th_afull0: got %0b expected 1", f_afull); end
    afull_th = 3'd2; aempty_th = 3'd0; #1;
    tests++;
    if (f_afull !== 1'b0 || f_aempty !== 1'b0) begin
      fails++; $display("FAIL th_mid: afull=%0b aempty=%0b expected 0/0", f_afull, f_aempty);
    end
    aempty_th = 3'd5; #1;
    tests++;
    if (f_aempty !== 1'b1) begin fails++; $display("FAIL th_aempty_depth: got %0b expected 1", f_aempty); end
    afull_th = 3'd4; aempty_th = 3'd1;
  endtask

  task automatic test_async_reset();
    flush = 1'b1; step(); flush = 1'b0;
    wren = 1'b1; wrdata = 8'h31; step(); wrdata = 8'h32; step(); wren = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (f_count !== 3'd0 || f_empty !== 1'b1) begin
      fails++; $display("FAIL async_rst: count=%0d empty=%0b expected 0/1", f_count, f_empty);
    end
    #1 rst = 1'b0;
    step();
    wren = 1'b1; wrdata = 8'h77; step(); wren = 1'b0;
    tests++;
    if (f_count !== 3'd1 || f_rddata !== 8'h77) begin
      fails++; $display("FAIL rst_resume: count=%0d data=%0h expected 1/77", f_count, f_rddata);
    end
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_std_latency();
    test_boundaries();
    test_flush();
    test_thresholds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
